rr_stream_arbiter: RTL and testbench

RR_STREAM_ARBITER -- requirements
Module: rr_stream_arbiter

---
 rtl/rr_stream_arbiter.sv | 124 ++++++++++++
 tb/tb_rr_stream_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_arbiter.sv
// Round-robin packet arbiter: N valid/ready streams into one.
// A grant holds for a whole packet, capped at MAX_BURST beats.
module rr_stream_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BURST  = 16,
   localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int BC_W      = $clog2(MAX_BURST) + 1
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          clear,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic                          out_valid,
   output logic                          out_last,
   output logic [ID_W-1:0]               out_id,
   input  logic                          out_ready
);

   localparam logic [ID_W:0]   NREQ    = (ID_W+1)'(NUM_REQ);
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(MAX_BURST - 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                state_r;
   logic [ID_W-1:0]       rr_ptr_r;
   logic [ID_W-1:0]       grant_r;
   logic [BC_W-1:0]       beat_cnt_r;
   logic [ID_W-1:0]       pick;
   logic [ID_W:0]         idx_sum;
   logic                  any_valid;
   logic                  can_take;
   logic                  in_xfer;
   logic                  out_xfer;
   logic                  burst_end;
   logic [ID_W-1:0]       next_ptr;
   logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign can_take  = !out_valid || out_ready;
   assign in_xfer   = (state_r == BURST) && req_valid[grant_r] && can_take;
   assign out_xfer  = out_valid && out_ready;
   assign burst_end = req_last[grant_r] || (beat_cnt_r == BC_LAST);
   assign next_ptr  = (grant_r == LAST_ID) ? '0 : grant_r + ID_W'(1);

   // Only the granted requester sees ready, and only when the out slot frees.
   always_comb begin
      req_ready = '0;
      if (state_r == BURST && can_take && rstn && !clear)
         req_ready[grant_r] = 1'b1;
   end

   // First valid requester at or after rr_ptr_r, wrapping modulo NUM_REQ.
   always_comb begin
      pick      = rr_ptr_r;
      any_valid = 1'b0;
      idx_sum   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx_sum = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
         if (idx_sum >= NREQ)
            idx_sum = idx_sum - NREQ;
         if (req_valid[idx_sum[ID_W-1:0]]) begin
            pick      = idx_sum[ID_W-1:0];
            any_valid = 1'b1;
         end
      end
   end

   // Output beat register: load on input transfer, drain on output transfer.
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_id    <= '0;
      end else if (in_xfer) begin
         out_valid <= 1'b1;
         out_data  <= data_arr[grant_r];
         out_last  <= req_last[grant_r];
         out_id    <= grant_r;
      end else if (out_xfer) begin
         out_valid <= 1'b0;
      end
   end

   // Arbitration FSM: one IDLE pick cycle, then a burst until last or cap.
   always_ff @(posedge clk) begin
      if (!rstn || clear) begin
         state_r    <= IDLE;
         rr_ptr_r   <= '0;
         grant_r    <= '0;
         beat_cnt_r <= '0;
      end else begin
         unique case (state_r)
            IDLE: begin
               if (any_valid) begin
                  grant_r    <= pick;
                  beat_cnt_r <= '0;
                  state_r    <= BURST;
               end
            end
            BURST: begin
               if (in_xfer) begin
                  beat_cnt_r <= beat_cnt_r + BC_W'(1);
                  if (burst_end) begin
                     state_r  <= IDLE;
                     rr_ptr_r <= next_ptr;
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Bench for rr_stream_arbiter: two configurations, a packet-level
// reference model, directed scenarios and randomized traffic.
module tb_rr_stream_arbiter;

   logic clk;
   logic rstn;

   logic [31:0] a_data;
   logic [3:0]  a_valid, a_last, a_ready;
   logic [7:0]  a_odata;
   logic        a_ov, a_ol, a_ordy, a_clr;
   logic [1:0]  a_oid;

   logic [39:0] b_data;
   logic [4:0]  b_valid, b_last, b_ready;
   logic [7:0]  b_odata;
   logic        b_ov, b_ol, b_ordy, b_clr;
   logic [2:0]  b_oid;

   rr_stream_arbiter #(.DATA_WIDTH(8), .NUM_REQ(4), .MAX_BURST(16)) dut_a (
      .clk(clk), .rstn(rstn), .clear(a_clr),
      .req_data(a_data), .req_valid(a_valid), .req_last(a_last),
      .req_ready(a_ready), .out_data(a_odata), .out_valid(a_ov),
      .out_last(a_ol), .out_id(a_oid), .out_ready(a_ordy));

   rr_stream_arbiter #(.DATA_WIDTH(8), .NUM_REQ(5), .MAX_BURST(4)) dut_b (
      .clk(clk), .rstn(rstn), .clear(b_clr),
      .req_data(b_data), .req_valid(b_valid), .req_last(b_last),
      .req_ready(b_ready), .out_data(b_odata), .out_valid(b_ov),
      .out_last(b_ol), .out_id(b_oid), .out_ready(b_ordy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total, passed, cyc;
   bit chk_en, rand_mode, rst_req;
   bit clr_req [2];

   // requester beat queues {last, data}
   logic [8:0] qm [2][5][256];
   int qh [2][5];
   int qt [2][5];

   int stall_from [2];
   int stall_len  [2];
   int gap_u, gap_i, gap_from, gap_len;

   // reference model state
   int         m_owner [2];
   int         m_ptr   [2];
   int         m_cnt   [2];
   bit         m_ov    [2];
   logic [7:0] m_od    [2];
   bit         m_ol    [2];
   int         m_oid   [2];

   // model output-transfer log
   int         lg_n  [2];
   int         lg_id [2][64];
   logic [7:0] lg_d  [2][64];
   bit         lg_l  [2][64];
   int         lg_c  [2][64];

   logic       last_ov  [2];
   logic [4:0] last_rdy [2];
   int run_cur, run_max;

   task automatic chk(input string nm, input int u,
                      input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s[%0d] cyc %0d: got %0h expected %0h",
                    nm, u, cyc, act, exp);
   endtask

   task automatic push(input int u, input int i,
                       input logic [7:0] d, input logic l);
      qm[u][i][qt[u][i]] = {l, d};
      qt[u][i]++;
   endtask

   task automatic flush_all();
      for (int u = 0; u < 2; u++)
         for (int i = 0; i < 5; i++) begin
            qh[u][i] = 0;
            qt[u][i] = 0;
         end
   endtask

   task automatic clr_log(input int u);
      lg_n[u] = 0;
      for (int k = 0; k < 64; k++) begin
         lg_id[u][k] = -1;
         lg_d[u][k]  = '0;
         lg_l[u][k]  = 1'b0;
         lg_c[u][k]  = 0;
      end
   endtask

   task automatic model_reset(input int u);
      m_owner[u] = -1;
      m_ptr[u]   = 0;
      m_cnt[u]   = 0;
      m_ov[u]    = 1'b0;
      m_od[u]    = '0;
      m_ol[u]    = 1'b0;
      m_oid[u]   = 0;
   endtask

   // compare DUT against model for this cycle, then advance the model
   task automatic step(input int u, input logic [4:0] vv,
                       input logic [39:0] dd, input logic [4:0] ll,
                       input logic ordy, input logic rst,
                       input logic [4:0] rdy, input logic ov,
                       input logic [7:0] od, input logic ol, input int oid);
      logic [4:0] er;
      int nr, mb, o, j;
      bit found;
      nr = (u == 0) ? 4 : 5;
      mb = (u == 0) ? 16 : 4;
      o  = m_owner[u];
      er = '0;
      if (!rst && o >= 0 && (!m_ov[u] || ordy)) er[o] = 1'b1;
      if (chk_en) begin
         chk("req_ready", u, 64'(rdy), 64'(er));
         chk("out_valid", u, 64'(ov), 64'(m_ov[u]));
         chk("out_data", u, 64'(od), 64'(m_od[u]));
         chk("out_last", u, 64'(ol), 64'(m_ol[u]));
         chk("out_id", u, 64'(oid), 64'(m_oid[u]));
      end
      last_ov[u]  = ov;
      last_rdy[u] = rdy;
      if (!rst && m_ov[u] && ordy && lg_n[u] < 64) begin
         lg_id[u][lg_n[u]] = m_oid[u];
         lg_d[u][lg_n[u]]  = m_od[u];
         lg_l[u][lg_n[u]]  = m_ol[u];
         lg_c[u][lg_n[u]]  = cyc;
         lg_n[u]++;
      end
      if (u == 0) begin
         run_cur = er[2] ? run_cur + 1 : 0;
         if (run_cur > run_max) run_max = run_cur;
      end
      if (rst) begin
         model_reset(u);
      end else begin
         if (o >= 0 && er[o] && vv[o]) begin
            m_ov[u]  = 1'b1;
            m_od[u]  = dd[o*8 +: 8];
            m_ol[u]  = ll[o];
            m_oid[u] = o;
            m_cnt[u]++;
            if (ll[o] || m_cnt[u] == mb) begin
               m_ptr[u]   = (o + 1) % nr;
               m_owner[u] = -1;
            end
         end else if (m_ov[u] && ordy) begin
            m_ov[u] = 1'b0;
         end
         if (o < 0) begin
            found = 1'b0;
            for (int k = 0; k < nr; k++) begin
               j = (m_ptr[u] + k) % nr;
               if (!found && vv[j]) begin
                  found      = 1'b1;
                  m_owner[u] = j;
                  m_cnt[u]   = 0;
               end
            end
         end
      end
   endtask

   task automatic cycle();
      logic [4:0]  vv [2];
      logic [39:0] dd [2];
      logic [4:0]  ll [2];
      logic        orr [2];
      bit          en, stl;
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         vv[u] = '0;
         dd[u] = '0;
         ll[u] = '0;
         for (int i = 0; i < ((u == 0) ? 4 : 5); i++) begin
            if (rand_mode) en = ($urandom_range(0, 9) < 8);
            else en = !(u == gap_u && i == gap_i && cyc >= gap_from &&
                        cyc < gap_from + gap_len);
            if (qh[u][i] != qt[u][i] && en) begin
               vv[u][i]        = 1'b1;
               dd[u][i*8 +: 8] = qm[u][i][qh[u][i]][7:0];
               ll[u][i]        = qm[u][i][qh[u][i]][8];
            end
         end
         stl = (cyc >= stall_from[u] && cyc < stall_from[u] + stall_len[u]);
         if (rand_mode) orr[u] = ($urandom_range(0, 3) != 0);
         else orr[u] = !stl;
      end
      rstn    = !rst_req;
      a_clr   = clr_req[0];
      b_clr   = clr_req[1];
      a_valid = vv[0][3:0];
      a_data  = dd[0][31:0];
      a_last  = ll[0][3:0];
      a_ordy  = orr[0];
      b_valid = vv[1];
      b_data  = dd[1];
      b_last  = ll[1];
      b_ordy  = orr[1];
      #1;
      step(0, vv[0], dd[0], ll[0], orr[0], !rstn || a_clr,
           {1'b0, a_ready}, a_ov, a_odata, a_ol, int'(a_oid));
      step(1, vv[1], dd[1], ll[1], orr[1], !rstn || b_clr,
           b_ready, b_ov, b_odata, b_ol, int'(b_oid));
      for (int i = 0; i < 4; i++)
         if (a_valid[i] && a_ready[i]) qh[0][i]++;
      for (int i = 0; i < 5; i++)
         if (b_valid[i] && b_ready[i]) qh[1][i]++;
      cyc++;
   endtask

   task automatic do_reset();
      flush_all();
      rst_req = 1'b1;
      cycle();
      rst_req = 1'b0;
      clr_log(0);
      clr_log(1);
      run_cur = 0;
      run_max = 0;
   endtask

   initial begin
      logic [7:0] exp_d [12];
      int exp_id [12];
      bit exp_l [12];
      int plen;
      total = 0; passed = 0; cyc = 0;
      chk_en = 1'b0; rand_mode = 1'b0; rst_req = 1'b0;
      clr_req[0] = 1'b0; clr_req[1] = 1'b0;
      rstn = 1'b0; a_clr = 1'b0; b_clr = 1'b0;
      a_data = '0; a_valid = '0; a_last = '0; a_ordy = 1'b0;
      b_data = '0; b_valid = '0; b_last = '0; b_ordy = 1'b0;
      stall_from[0] = 0; stall_from[1] = 0;
      stall_len[0] = 0; stall_len[1] = 0;
      gap_u = 0; gap_i = 0; gap_from = 0; gap_len = 0;
      model_reset(0);
      model_reset(1);
      do_reset();
      chk_en = 1'b1;
      do_reset();

      // all four requesters, one-beat packets: ids 0,1,2,3,0 every 2 cycles
      push(0, 0, 8'h10, 1'b1);
      push(0, 0, 8'h11, 1'b1);
      push(0, 1, 8'h20, 1'b1);
      push(0, 2, 8'h30, 1'b1);
      push(0, 3, 8'h40, 1'b1);
      repeat (14) cycle();
      chk("t1_count", 0, 64'(lg_n[0]), 64'd5);
      for (int k = 0; k < 5; k++)
         chk("t1_id", 0, 64'(lg_id[0][k]), 64'((k == 4) ? 0 : k));
      for (int k = 0; k < 4; k++)
         chk("t1_spacing", 0, 64'(lg_c[0][k+1] - lg_c[0][k]), 64'd2);
      chk("t1_data_last", 0, 64'(lg_d[0][4]), 64'h11);

      // requester 2 five-beat packet
      do_reset();
      for (int k = 0; k < 5; k++)
         push(0, 2, 8'(8'h21 + k), k == 4);
      repeat (10) cycle();
      chk("t2_ready_run", 0, 64'(run_max), 64'd5);
      chk("t2_count", 0, 64'(lg_n[0]), 64'd5);
      for (int k = 0; k < 5; k++) begin
         chk("t2_data", 0, 64'(lg_d[0][k]), 64'(8'h21 + k));
         chk("t2_last", 0, 64'(lg_l[0][k]), 64'(k == 4));
      end

      // MAX_BURST=4, 5 requesters: req 1 ten beats vs req 3 single beats
      do_reset();
      for (int k = 0; k < 10; k++)
         push(1, 1, 8'(8'h51 + k), k == 9);
      push(1, 3, 8'h71, 1'b1);
      push(1, 3, 8'h72, 1'b1);
      repeat (30) cycle();
      exp_id = '{1, 1, 1, 1, 3, 1, 1, 1, 1, 3, 1, 1};
      exp_l  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1};
      exp_d  = '{8'h51, 8'h52, 8'h53, 8'h54, 8'h71, 8'h55,
                 8'h56, 8'h57, 8'h58, 8'h72, 8'h59, 8'h5a};
      chk("t3_count", 1, 64'(lg_n[1]), 64'd12);
      for (int k = 0; k < 12; k++) begin
         chk("t3_id", 1, 64'(lg_id[1][k]), 64'(exp_id[k]));
         chk("t3_last", 1, 64'(lg_l[1][k]), 64'(exp_l[k]));
         chk("t3_data", 1, 64'(lg_d[1][k]), 64'(exp_d[k]));
      end

      // downstream stall of 3 cycles mid-burst
      do_reset();
      for (int k = 0; k < 8; k++)
         push(0, 0, 8'(8'h81 + k), k == 7);
      stall_from[0] = cyc + 3;
      stall_len[0]  = 3;
      repeat (20) cycle();
      stall_len[0] = 0;
      chk("t4_count", 0, 64'(lg_n[0]), 64'd8);
      for (int k = 0; k < 8; k++)
         chk("t4_data", 0, 64'(lg_d[0][k]), 64'(8'h81 + k));

      // granted requester drops valid for 2 cycles while another waits
      do_reset();
      for (int k = 0; k < 6; k++)
         push(0, 1, 8'(8'h91 + k), k == 5);
      push(0, 2, 8'ha1, 1'b1);
      gap_u = 0; gap_i = 1; gap_from = cyc + 4; gap_len = 2;
      repeat (20) cycle();
      gap_len = 0;
      chk("t5_count", 0, 64'(lg_n[0]), 64'd7);
      for (int k = 0; k < 7; k++)
         chk("t5_id", 0, 64'(lg_id[0][k]), 64'((k == 6) ? 2 : 1));

      // clear with a held output beat mid-burst
      do_reset();
      for (int k = 0; k < 8; k++)
         push(0, 3, 8'(8'hb1 + k), k == 7);
      repeat (4) cycle();
      push(0, 1, 8'hc1, 1'b1);
      push(0, 2, 8'hd1, 1'b1);
      chk("t6_held_valid", 0, 64'(m_ov[0]), 64'd1);
      clr_req[0] = 1'b1;
      cycle();
      clr_req[0] = 1'b0;
      clr_log(0);
      cycle();
      chk("t6_ov_after_clear", 0, 64'(last_ov[0]), 64'd0);
      chk("t6_rdy_after_clear", 0, 64'(last_rdy[0]), 64'd0);
      repeat (10) cycle();
      chk("t6_first_id", 0, 64'(lg_id[0][0]), 64'd1);
      chk("t6_first_data", 0, 64'(lg_d[0][0]), 64'hc1);

      // randomized traffic on both instances
      do_reset();
      rand_mode = 1'b1;
      for (int n = 0; n < 4000; n++) begin
         for (int u = 0; u < 2; u++)
            for (int i = 0; i < ((u == 0) ? 4 : 5); i++)
               if (qh[u][i] == qt[u][i] && $urandom_range(0, 3) == 0) begin
                  qh[u][i] = 0;
                  qt[u][i] = 0;
                  plen = $urandom_range(1, 20);
                  for (int k = 0; k < plen; k++)
                     push(u, i, 8'($urandom_range(0, 255)), k == plen - 1);
               end
         rst_req    = ($urandom_range(0, 999) == 0);
         clr_req[0] = ($urandom_range(0, 299) == 0);
         clr_req[1] = ($urandom_range(0, 299) == 0);
         cycle();
      end
      rst_req = 1'b0;
      clr_req[0] = 1'b0;
      clr_req[1] = 1'b0;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
